// File: rtl/bch_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised BCH encoder.
package bch_pkg;

  localparam int          BCH_N_DEF    = 63;
  localparam int          BCH_K_DEF    = 51;
  localparam logic [12:0] BCH_POLY_DEF = 13'h1539;

  typedef enum logic {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } bch_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int poly_degree(input logic [1023:0] p);
    int d;
    d = 0;
    for (int i = 0; i < 1024; i++) begin
      if (p[i]) d = i;
    end
    return d;
  endfunction

endpackage

// File: rtl/bch_encoder_param_if.sv
// Bit-serial input/output stream plus codeword counter of the BCH encoder.
interface bch_encoder_param_if #(
  parameter int CNT_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic             s_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_data;
  logic             m_first;
  logic             m_last;
  logic [CNT_W-1:0] cw_count;

  // master: the encoder side; slave: source/sink environment
  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_first, m_last, cw_count
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_first, m_last, cw_count
  );
endinterface

// File: rtl/bch_lfsr_rem.sv
// Remainder LFSR over g(x): divides the shifted-in message, then shifts the remainder out MSB first.
module bch_lfsr_rem #(
  parameter int         R    = 12,
  parameter logic [R:0] POLY = 13'h1539
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic shift_in_en,
  input  logic par_shift_en,
  input  logic din,
  output logic msb
);

  logic [R-1:0] rem_q, rem_d;
  logic         fb;

  assign fb  = din ^ rem_q[R-1];
  assign msb = rem_q[R-1];

  always_comb begin
    rem_d = rem_q;
    if (clr) begin
      rem_d = '0;
    end else if (shift_in_en) begin
      rem_d = (rem_q << 1) ^ (fb ? POLY[R-1:0] : '0);
    end else if (par_shift_en) begin
      rem_d = rem_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem_q <= '0;
    else        rem_q <= rem_d;
  end

endmodule

// File: rtl/bch_encoder_param.sv
// Systematic bit-serial BCH encoder: echoes K message bits, then appends N-K parity bits.
//
// state  | meaning
// ST_MSG | accepting message bits, each echoed to the output register
// ST_PAR | emitting the LFSR remainder as parity, input held off
module bch_encoder_param
  import bch_pkg::*;
#(
  parameter int           N        = BCH_N_DEF,
  parameter int           K        = BCH_K_DEF,
  parameter logic [N-K:0] GEN_POLY = BCH_POLY_DEF,
  parameter int           CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  bch_encoder_param_if.master bus
);

  localparam int            R          = N - K;
  localparam int            CW         = clog2(N);
  localparam logic [CW-1:0] CNT_K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] CNT_R_LAST = CW'(R - 1);

  if (N <= K || N > 1023) begin : g_bad_nk
    $error("bch_encoder_param: need K < N <= 1023");
  end
  if (poly_degree(1024'(GEN_POLY)) != R || GEN_POLY[0] != 1'b1) begin : g_bad_poly
    $error("bch_encoder_param: GEN_POLY must have degree N-K and constant term 1");
  end

  bch_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_data_q, m_data_d;
  logic             m_first_q, m_first_d;
  logic             m_last_q, m_last_d;
  logic [CNT_W-1:0] cw_cnt_q, cw_cnt_d;

  logic free, s_ready, in_xfer;
  logic lfsr_clr, lfsr_shift_in, lfsr_par_shift, lfsr_msb;

  assign free    = !m_valid_q || bus.m_ready;
  assign s_ready = (state_q == ST_MSG) && free && rst_n;
  assign in_xfer = bus.s_valid && s_ready;

  bch_lfsr_rem #(
    .R    (R),
    .POLY (GEN_POLY)
  ) u_rem (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (lfsr_clr),
    .shift_in_en  (lfsr_shift_in),
    .par_shift_en (lfsr_par_shift),
    .din          (bus.s_data),
    .msb          (lfsr_msb)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_first_d      = m_first_q;
    m_last_d       = m_last_q;
    cw_cnt_d       = cw_cnt_q;
    lfsr_clr       = 1'b0;
    lfsr_shift_in  = 1'b0;
    lfsr_par_shift = 1'b0;

    // Drained output register with nothing new to load goes idle.
    if (free) m_valid_d = 1'b0;

    case (state_q)
      ST_MSG: begin
        if (in_xfer) begin
          m_valid_d     = 1'b1;
          m_data_d      = bus.s_data;
          m_first_d     = (cnt_q == '0);
          m_last_d      = 1'b0;
          lfsr_shift_in = 1'b1;
          if (cnt_q == CNT_K_LAST) begin
            cnt_d   = '0;
            state_d = ST_PAR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_PAR: begin
        if (free) begin
          m_valid_d = 1'b1;
          m_data_d  = lfsr_msb;
          m_first_d = 1'b0;
          m_last_d  = (cnt_q == CNT_R_LAST);
          if (cnt_q == CNT_R_LAST) begin
            cnt_d    = '0;
            state_d  = ST_MSG;
            lfsr_clr = 1'b1;
            cw_cnt_d = cw_cnt_q + CNT_W'(1);
          end else begin
            lfsr_par_shift = 1'b1;
            cnt_d          = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_MSG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_MSG;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      cw_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
      cw_cnt_q  <= cw_cnt_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_first  = m_first_q;
  assign bus.m_last   = m_last_q;
  assign bus.cw_count = cw_cnt_q;

endmodule

// File: tb/tb_bch_encoder_param.sv
// Directed bench for bch_encoder_param: BCH(63,51) default instance plus a (15,7) instance with a 2-bit counter.
module tb_bch_encoder_param;
  import bch_pkg::*;

  typedef struct {
    logic [50:0] msg;
    logic [11:0] par;
  } vec_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  bit   throttle = 1'b0;
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   sr_low   = 0;

  bit q0_d[$];
  bit q0_f[$];
  bit q0_l[$];
  int q0_c[$];
  bit q1_d[$];

  bit         st_v   = 1'b0;
  logic [2:0] st_val = '0;

  bch_encoder_param_if #(.CNT_W(16)) bus0 ();
  bch_encoder_param_if #(.CNT_W(2))  bus1 ();

  bch_encoder_param #(.N(63), .K(51), .GEN_POLY(13'h1539), .CNT_W(16)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  bch_encoder_param #(.N(15), .K(7), .GEN_POLY(9'h1D1), .CNT_W(2)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bus0.m_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    bus1.m_ready = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic abort(input string why);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", why);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench aborted");
  endtask

  // Output collector and stall-stability watcher
  always @(negedge clk) begin
    if (!rst_n) begin
      st_v = 1'b0;
    end else begin
      if (st_v)
        check("stall_hold", 64'({bus0.m_valid, bus0.m_data, bus0.m_first, bus0.m_last}),
              64'({1'b1, st_val}));
      if (bus0.m_valid && bus0.m_ready) begin
        q0_d.push_back(bus0.m_data);
        q0_f.push_back(bus0.m_first);
        q0_l.push_back(bus0.m_last);
        q0_c.push_back(cyc);
        st_v = 1'b0;
      end else if (bus0.m_valid) begin
        st_v   = 1'b1;
        st_val = {bus0.m_data, bus0.m_first, bus0.m_last};
      end else begin
        st_v = 1'b0;
      end
      if (!bus0.s_ready) sr_low++;
      if (bus1.m_valid && bus1.m_ready) q1_d.push_back(bus1.m_data);
    end
  end

  // Reference: long division of msg * x^r by g
  function automatic logic [15:0] model_par(input logic [63:0] msg, input int k, input int r,
                                            input logic [16:0] g);
    logic [79:0] d;
    logic [15:0] p;
    d = 80'(msg) << r;
    for (int i = k + r - 1; i >= r; i--) begin
      if (d[i]) d = d ^ (80'(g) << (i - r));
    end
    p = '0;
    for (int j = 0; j < r; j++) p[j] = d[j];
    return p;
  endfunction

  task automatic accept0();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus0.s_ready) break;
      n++;
      if (n > 5000) abort("s_ready0_wait");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic accept1();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus1.s_ready) break;
      n++;
      if (n > 5000) abort("s_ready1_wait");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [50:0] msg, input bit gaps);
    for (int i = 50; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus0.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus0.s_valid = 1'b1;
      bus0.s_data  = msg[i];
      accept0();
    end
    bus0.s_valid = 1'b0;
  endtask

  task automatic send1(input logic [6:0] msg);
    for (int i = 6; i >= 0; i--) begin
      bus1.s_valid = 1'b1;
      bus1.s_data  = msg[i];
      accept1();
    end
    bus1.s_valid = 1'b0;
  endtask

  task automatic wait_q0(input int n, input int budget);
    for (int i = 0; i < budget && q0_d.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    if (q0_d.size() < n) abort("out0_count");
  endtask

  task automatic wait_q1(input int n, input int budget);
    for (int i = 0; i < budget && q1_d.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    if (q1_d.size() < n) abort("out1_count");
  endtask

  task automatic check_cw0(input int base, input logic [50:0] msg, input logic [11:0] par,
                           input string tag);
    logic [62:0] gd, gf, gl;
    for (int j = 0; j < 63; j++) begin
      gd[62-j] = q0_d[base+j];
      gf[62-j] = q0_f[base+j];
      gl[62-j] = q0_l[base+j];
    end
    check($sformatf("%s_data", tag), 64'(gd), 64'({msg, par}));
    check($sformatf("%s_first", tag), 64'(gf), 64'(63'd1 << 62));
    check($sformatf("%s_last", tag), 64'(gl), 64'd1);
  endtask

  initial begin
    vec_t        vecs[3];
    logic [50:0] words[10];
    logic [14:0] small_cw;
    int          base;
    int          s0;

    vecs[0] = '{msg: 51'd0, par: 12'd0};
    vecs[1] = '{msg: 51'd1, par: 12'b010100111001};
    vecs[2] = '{msg: 51'b100001001010111101101000011010000010010110101010110,
                par: 12'b110000000110};

    bus0.s_valid = 1'b0;
    bus0.s_data  = 1'b0;
    bus1.s_valid = 1'b0;
    bus1.s_data  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out0", 64'({bus0.m_valid, bus0.m_data, bus0.m_first, bus0.m_last, bus0.s_ready}),
          64'd0);
    check("rst_cnt0", 64'(bus0.cw_count), 64'd0);
    check("rst_out1", 64'({bus1.m_valid, bus1.s_ready, bus1.cw_count}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      base = q0_d.size();
      s0   = sr_low;
      send0(vecs[i].msg, 1'b0);
      wait_q0(base + 63, 500);
      check_cw0(base, vecs[i].msg, vecs[i].par, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_cnt", i), 64'(bus0.cw_count), 64'(i + 1));
      check($sformatf("vec%0d_sready_low", i), 64'(sr_low - s0), 64'd12);
    end

    for (int w = 0; w < 10; w++) words[w] = 51'({$urandom(), $urandom()});

    // Back-to-back words at full rate
    @(posedge clk);
    #1;
    base = q0_d.size();
    for (int w = 0; w < 10; w++) send0(words[w], 1'b0);
    wait_q0(base + 630, 2000);
    for (int w = 0; w < 10; w++)
      check_cw0(base + 63 * w, words[w], 12'(model_par(64'(words[w]), 51, 12, 17'h1539)),
                $sformatf("b2b%0d", w));
    check("b2b_span", 64'(q0_c[base+629] - q0_c[base]), 64'd629);
    check("b2b_cnt", 64'(bus0.cw_count), 64'd13);

    // Same words with random backpressure and input gaps
    throttle = 1'b1;
    @(posedge clk);
    #1;
    base = q0_d.size();
    for (int w = 0; w < 10; w++) send0(words[w], 1'b1);
    wait_q0(base + 630, 20000);
    throttle = 1'b0;
    for (int w = 0; w < 10; w++)
      check_cw0(base + 63 * w, words[w], 12'(model_par(64'(words[w]), 51, 12, 17'h1539)),
                $sformatf("thr%0d", w));
    check("thr_cnt", 64'(bus0.cw_count), 64'd23);

    // Asynchronous reset while parity bit 5 sits in the output register
    @(posedge clk);
    #1;
    base = q0_d.size();
    send0(vecs[2].msg, 1'b0);
    wait_q0(base + 56, 500);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 64'({bus0.m_valid, bus0.m_data, bus0.m_first, bus0.m_last, bus0.s_ready}),
          64'd0);
    check("arst_cnt", 64'(bus0.cw_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = q0_d.size();
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_tail", 64'(q0_d.size() - base), 64'd0);
    send0(vecs[2].msg, 1'b0);
    wait_q0(base + 63, 500);
    check_cw0(base, vecs[2].msg, vecs[2].par, "post_rst");
    check("post_rst_cnt", 64'(bus0.cw_count), 64'd1);

    // (15,7) instance: parity of x^8 and 2-bit counter wrap
    for (int w = 0; w < 4; w++) begin
      @(posedge clk);
      #1;
      base = q1_d.size();
      send1(7'b0000001);
      wait_q1(base + 15, 200);
      for (int j = 0; j < 15; j++) small_cw[14-j] = q1_d[base+j];
      check($sformatf("small_cw%0d", w), 64'(small_cw), 64'({7'b0000001, 8'b11010001}));
      check($sformatf("small_cnt%0d", w), 64'(bus1.cw_count), 64'((w + 1) % 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
